alu_bist: RTL
=============

Name: alu_bist

Overview:
- Built-in self-test initiator for the ALU.
- Drives the ALU's operand/opcode side (portA, portB, aluOp) with pseudo-random operands and walks all ten ALU operations.
- Compresses every result and flag set into a 32-bit MISR signature, then compares it against a golden value.
- Sits beside the ALU in the datapath test wrapper; muxing between BIST and pipeline operands is outside this block.

Parameters:
NUM_VECTORS, 64, operand vectors applied per ALU operation (legal 1..65535)
SEED_A, 32'hACE12468, initial state of operand-A LFSR (zero is replaced by 32'h00000001)
SEED_B, 32'h13579BDF, initial state of operand-B LFSR (zero is replaced by 32'h00000001)
GOLDEN_SIG, 32'h00000000, expected final signature, set per build from the golden model

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset; one clock, synchronous, active-high
start  in  1  begin a test run; sampled in IDLE and DONE only
busy  out  1  high while in RUN
done  out  1  high while in DONE
pass  out  1  valid while done=1: signature == GOLDEN_SIG
signature  out  32  current MISR state
alu_op  out  aluop_t  operation driven to the ALU
port_a  out  32  operand A driven to the ALU
port_b  out  32  operand B driven to the ALU
port_out  in  32  ALU result (combinational response to port_a/port_b/alu_op)
negative  in  1  ALU negative flag
overflow  in  1  ALU overflow flag
zero  in  1  ALU zero flag

Behaviour:
- Reset (RST=1 at a rising edge) forces the following; reset mid-RUN aborts the run with no done pulse:
  - state=IDLE
  - busy=0, done=0, pass=0
  - signature=0
  - port_a=0, port_b=0
  - alu_op=ALU_SLL
  - op_idx=0, vec_cnt=0
- FSM states: IDLE, RUN, DONE.
  - IDLE: outputs held at reset values. start=1 on an edge → RUN; that same edge loads LFSR_A=SEED_A, LFSR_B=SEED_B, signature=0, op_idx=0, vec_cnt=0.
  - RUN: start is ignored. When op_idx=9 and vec_cnt=NUM_VECTORS-1 on an edge → DONE.
  - DONE: done=1 and pass held. start=1 → RUN with full re-initialisation, identical to start from IDLE. Otherwise the block holds DONE indefinitely.
- Operation order by op_idx 0..9: SLL, SRL, ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU.
- Operands in RUN, registered and driven from the current LFSR state:
  - port_a = LFSR_A.
  - port_b = LFSR_B, except for SLL/SRL, where port_b = {27'b0, LFSR_B[4:0]}.
- Per RUN edge:
  - signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ (port_out ^ {29'b0, overflow, zero, negative}).
  - Both LFSRs step: L <= {L[30:0], L[31]^L[21]^L[1]^L[0]}.
  - vec_cnt increments. At NUM_VECTORS-1 it wraps to 0 and op_idx increments.
  - Operands and op update together, so the ALU sees new stimulus every cycle.
- Timing:
  - ALU path is combinational, so results are captured in the cycle they are driven.
  - RUN lasts exactly 10*NUM_VECTORS cycles.
  - busy falls and done rises on the same edge.
- pass is registered on the DONE-entry edge from the final signature value, which includes the last vector.
- In DONE, port_a, port_b and alu_op return to 0/0/ALU_SLL; signature holds.
- NUM_VECTORS=1: each op is applied once; RUN lasts 10 cycles.

Test Plan:
- Reset then idle: RST high 2 cycles, start=0 for 20 cycles → busy=0, done=0, pass=0, signature=0, port_a=0, port_b=0, alu_op=ALU_SLL throughout.
- First vectors: pulse start → next cycle busy=1, alu_op=ALU_SLL, port_a=32'hACE12468, port_b=32'h0000001F. After NUM_VECTORS cycles alu_op=ALU_SRL.
- Full run, default params, ALU instance connected, GOLDEN_SIG from bench reference model:
  - busy high for exactly 640 cycles.
  - Then done=1, pass=1, signature equals the model value.
  - Model applies the identical LFSR/MISR equations to a behavioural ALU.
- Fault detection: same run with the ALU's ADD result bit 0 forced to 0 → done=1, pass=0, signature≠GOLDEN_SIG.
- Start handling:
  - start held high throughout RUN → no restart; done after 640 cycles.
  - start in DONE → re-run with signature reset to 0 and identical final signature.
- Reset mid-run: RST at cycle 300 of RUN → next edge IDLE, busy=0, done=0, signature=0. A subsequent start completes normally with pass=1.

Source files
------------

// File: rtl/alu_bist.sv
// ALU built-in self-test: drives LFSR operands through all ten ALU operations and
// compresses every result and flag set into a 32-bit MISR that is compared to a golden value.

package alu_bist_pkg;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;
endpackage

module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [31:0] SEED_A      = 32'hACE12468,
    parameter logic [31:0] SEED_B      = 32'h13579BDF,
    parameter logic [31:0] GOLDEN_SIG  = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output aluop_t      alu_op,
    output logic [31:0] port_a,
    output logic [31:0] port_b,
    input  logic [31:0] port_out,
    input  logic        negative,
    input  logic        overflow,
    input  logic        zero
);

    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  RUN  = 2'd1;
    localparam logic [1:0]  DONE = 2'd2;

    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_OP  = 4'd9;

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [31:0] SEED_A_INIT = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0] SEED_B_INIT = (SEED_B == 32'd0) ? 32'd1 : SEED_B;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Shift operations only see a 5-bit shift amount.
    function automatic logic [31:0] shape_b(input logic [3:0] op, input logic [31:0] b);
        return (op < 4'd2) ? {27'b0, b[4:0]} : b;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] lfsr_a_q, lfsr_a_d;
    logic [31:0] lfsr_b_q, lfsr_b_d;
    logic [31:0] port_b_q, port_b_d;
    logic [31:0] sig_q, sig_d;
    logic [3:0]  op_idx_q, op_idx_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic        pass_q, pass_d;

    logic        last_vec;
    logic [31:0] lfsr_b_next;

    always_comb begin
        state_d     = state_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        port_b_d    = port_b_q;
        sig_d       = sig_q;
        op_idx_d    = op_idx_q;
        vec_cnt_d   = vec_cnt_q;
        pass_d      = pass_q;
        last_vec    = (vec_cnt_q == LAST_VEC);
        lfsr_b_next = lfsr_step(lfsr_b_q);

        case (state_q)
            RUN: begin
                sig_d = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]}
                        ^ (port_out ^ {29'b0, overflow, zero, negative});
                if (last_vec && op_idx_q == LAST_OP) begin
                    state_d   = DONE;
                    pass_d    = (sig_d == GOLDEN_SIG);
                    lfsr_a_d  = 32'd0;
                    port_b_d  = 32'd0;
                    op_idx_d  = 4'd0;
                    vec_cnt_d = 16'd0;
                end else begin
                    lfsr_a_d  = lfsr_step(lfsr_a_q);
                    lfsr_b_d  = lfsr_b_next;
                    vec_cnt_d = last_vec ? 16'd0 : vec_cnt_q + 16'd1;
                    op_idx_d  = last_vec ? op_idx_q + 4'd1 : op_idx_q;
                    port_b_d  = shape_b(op_idx_d, lfsr_b_next);
                end
            end
            default: begin
                // IDLE and DONE both accept start with a full re-initialisation.
                if (start) begin
                    state_d   = RUN;
                    lfsr_a_d  = SEED_A_INIT;
                    lfsr_b_d  = SEED_B_INIT;
                    port_b_d  = shape_b(4'd0, SEED_B_INIT);
                    sig_d     = 32'd0;
                    pass_d    = 1'b0;
                    op_idx_d  = 4'd0;
                    vec_cnt_d = 16'd0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            lfsr_a_q  <= 32'd0;
            lfsr_b_q  <= 32'd0;
            port_b_q  <= 32'd0;
            sig_q     <= 32'd0;
            op_idx_q  <= 4'd0;
            vec_cnt_q <= 16'd0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_a_q  <= lfsr_a_d;
            lfsr_b_q  <= lfsr_b_d;
            port_b_q  <= port_b_d;
            sig_q     <= sig_d;
            op_idx_q  <= op_idx_d;
            vec_cnt_q <= vec_cnt_d;
            pass_q    <= pass_d;
        end
    end

    // Operand A register doubles as the LFSR; it is cleared outside RUN.
    assign port_a    = lfsr_a_q;
    assign port_b    = port_b_q;
    assign alu_op    = aluop_t'(op_idx_q);
    assign signature = sig_q;
    assign pass      = pass_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
